piso_tx: RTL and testbench

Parallel-in/serial-out transmitter: the serializing counterpart to the team's 4-bit parallel register stage. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled cycle, with frame markers. Back-to-back words stream with no idle bit between them. It sits between a parallel datapath register and a serial link or pin driver.

---
 rtl/piso_tx_if.sv | 32 +++
 rtl/piso_tx.sv | 99 +++++++++
 tb/tb_piso_tx.sv | 126 ++++++++++++
 3 files changed

// File: rtl/piso_tx_if.sv
// piso_tx_if: handshake and serial-side signal bundle for piso_tx.
//   parallel_in  - word to transmit (source -> transmitter)
//   load_valid   - parallel_in holds a word (source -> transmitter)
//   load_ready   - transmitter can take a word this cycle (transmitter -> source)
//   shift_en     - bit-rate enable (source -> transmitter)
//   serial_out   - current serial bit
//   serial_valid - serial_out carries a data bit
//   frame_start  - current bit is the first bit of a word
//   frame_end    - current bit is the last bit of a word
// master = the feeding/observing side, slave = the transmitter.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] parallel_in;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             frame_end;

  modport master (
    output parallel_in, load_valid, shift_en,
    input  load_ready, serial_out, serial_valid, frame_start, frame_end
  );

  modport slave (
    input  parallel_in, load_valid, shift_en,
    output load_ready, serial_out, serial_valid, frame_start, frame_end
  );
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter with frame markers.
// Takes a WIDTH-bit word over load_valid/load_ready and shifts it out one bit
// per shift_en cycle, first bit visible the cycle after acceptance. A new word
// may be accepted on the last enabled bit, so words stream with no gap.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-high reset; all outputs 0 while high
//   bus   - piso_tx_if.slave (handshake, shift enable, serial outputs)
// Parameters:
//   WIDTH     - word width, >= 2
//   MSB_FIRST - 1: bit WIDTH-1 goes first (shift left); 0: bit 0 first (shift right)
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic     clock,
  input  logic     reset,
  piso_tx_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             shifting;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] shifted;

  assign shifting = (state_q == SHIFT);
  assign last_bit = (cnt_q == '0);

  // Ready in IDLE, or on the last bit of a word when it is actually leaving
  // this cycle; that is what makes back-to-back words gapless.
  assign bus.load_ready = !reset &&
                          (state_q == IDLE || (shifting && last_bit && bus.shift_en));
  assign accept = bus.load_valid && bus.load_ready;

  // Move the next bit toward the output end, zero fill behind it.
  assign shifted = MSB_FIRST ? {shift_reg_q[WIDTH-2:0], 1'b0}
                             : {1'b0, shift_reg_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    shift_reg_d = shift_reg_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_reg_d = bus.parallel_in;
          cnt_d       = CNT_MAX;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          if (!last_bit) begin
            shift_reg_d = shifted;
            cnt_d       = cnt_q - CW'(1);
          end else if (accept) begin
            shift_reg_d = bus.parallel_in;
            cnt_d       = CNT_MAX;
          end else begin
            shift_reg_d = '0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        shift_reg_d = '0;
        cnt_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_reg_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shift_reg_q <= shift_reg_d;
      cnt_q       <= cnt_d;
    end
  end

  // State resets asynchronously, so these drop to 0 as soon as reset rises.
  assign bus.serial_out   = shifting &&
                            (MSB_FIRST ? shift_reg_q[WIDTH-1] : shift_reg_q[0]);
  assign bus.serial_valid = shifting;
  assign bus.frame_start  = shifting && (cnt_q == CNT_MAX);
  assign bus.frame_end    = shifting && last_bit;
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed bench for piso_tx. Three instances:
//   a: WIDTH=4 MSB first, b: WIDTH=4 LSB first, c: WIDTH=8 MSB first.
// Expected output vectors are {load_ready, serial_valid, serial_out,
// frame_start, frame_end}, one per cycle, worked out by hand.
module tb_piso_tx;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  piso_tx_if #(.WIDTH(4)) a_if ();
  piso_tx_if #(.WIDTH(4)) b_if ();
  piso_tx_if #(.WIDTH(8)) c_if ();

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_a (.clock(clock), .reset(reset), .bus(a_if));
  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_b (.clock(clock), .reset(reset), .bus(b_if));
  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_c (.clock(clock), .reset(reset), .bus(c_if));

  logic [4:0] obs_a, obs_b, obs_c;
  assign obs_a = {a_if.load_ready, a_if.serial_valid, a_if.serial_out, a_if.frame_start, a_if.frame_end};
  assign obs_b = {b_if.load_ready, b_if.serial_valid, b_if.serial_out, b_if.frame_start, b_if.frame_end};
  assign obs_c = {c_if.load_ready, c_if.serial_valid, c_if.serial_out, c_if.frame_start, c_if.frame_end};

  int n_chk = 0;
  int n_err = 0;

  logic [4:0] e_msb [6]  = '{5'b10000, 5'b01110, 5'b01000, 5'b01100, 5'b11101, 5'b10000};
  logic [4:0] e_lsb [6]  = '{5'b10000, 5'b01110, 5'b01100, 5'b01000, 5'b11101, 5'b10000};
  logic [4:0] e_b2b [10] = '{5'b10000, 5'b01110, 5'b01000, 5'b01100, 5'b11001,
                             5'b01010, 5'b01100, 5'b01000, 5'b11101, 5'b10000};
  logic [4:0] e_stl [12] = '{5'b10000, 5'b01110, 5'b01100, 5'b01100, 5'b01000, 5'b01001,
                             5'b11001, 5'b01010, 5'b01000, 5'b01100, 5'b11101, 5'b10000};
  logic [11:0] stl_lv    = 12'b0000_0111_1101; // bit i = load_valid in cycle i
  logic [11:0] stl_se    = 12'b1111_1101_1011; // bit i = shift_en in cycle i
  logic [4:0] e_pre [3]  = '{5'b10000, 5'b01110, 5'b01100};
  logic [4:0] e_post [6] = '{5'b10000, 5'b01010, 5'b01100, 5'b01100, 5'b11001, 5'b10000};
  logic [4:0] e_w8 [10]  = '{5'b10000, 5'b01110, 5'b01000, 5'b01000, 5'b01000,
                             5'b01000, 5'b01000, 5'b01000, 5'b11101, 5'b10000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got[4:0], exp[4:0]);
    end
  endtask

  // One cycle on instance d (0=a,1=b,2=c): drive inputs, let them settle,
  // compare outputs, then step to 1 time unit past the next rising edge.
  task automatic cyc(input int d, input logic lv, input logic [7:0] din, input logic se,
                     input logic [4:0] exp, input string tag);
    a_if.load_valid = 1'b0; a_if.shift_en = 1'b1;
    b_if.load_valid = 1'b0; b_if.shift_en = 1'b1;
    c_if.load_valid = 1'b0; c_if.shift_en = 1'b1;
    case (d)
      0: begin a_if.load_valid = lv; a_if.parallel_in = din[3:0]; a_if.shift_en = se; end
      1: begin b_if.load_valid = lv; b_if.parallel_in = din[3:0]; b_if.shift_en = se; end
      default: begin c_if.load_valid = lv; c_if.parallel_in = din; c_if.shift_en = se; end
    endcase
    #1;
    case (d)
      0: check(tag, {27'd0, obs_a}, {27'd0, exp});
      1: check(tag, {27'd0, obs_b}, {27'd0, exp});
      default: check(tag, {27'd0, obs_c}, {27'd0, exp});
    endcase
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset with load_valid high everywhere: nothing may be ready or valid.
    a_if.parallel_in = 4'hF; a_if.load_valid = 1'b1; a_if.shift_en = 1'b1;
    b_if.parallel_in = 4'hF; b_if.load_valid = 1'b1; b_if.shift_en = 1'b1;
    c_if.parallel_in = 8'hFF; c_if.load_valid = 1'b1; c_if.shift_en = 1'b1;
    #3;
    check("reset a", {27'd0, obs_a}, 32'd0);
    check("reset b", {27'd0, obs_b}, 32'd0);
    check("reset c", {27'd0, obs_c}, 32'd0);
    a_if.load_valid = 1'b0; b_if.load_valid = 1'b0; c_if.load_valid = 1'b0;
    #9 reset = 1'b0;
    @(posedge clock);
    #1;

    // First word, MSB first: 1011 -> 1,0,1,1
    for (int i = 0; i < 6; i++)
      cyc(0, i == 0, 8'hB, 1'b1, e_msb[i], $sformatf("msb c%0d", i));

    // LSB first: 1011 -> 1,1,0,1
    for (int i = 0; i < 6; i++)
      cyc(1, i == 0, 8'hB, 1'b1, e_lsb[i], $sformatf("lsb c%0d", i));

    // Back-to-back A then 5, load_valid held through the first word
    for (int i = 0; i < 10; i++)
      cyc(0, i < 5, (i == 0) ? 8'hA : 8'h5, 1'b1, e_b2b[i], $sformatf("b2b c%0d", i));

    // Stall on bit 1 of C, then a pending load of 3 held off until an
    // enabled last bit (also stalled once on the last bit)
    for (int i = 0; i < 12; i++)
      cyc(0, stl_lv[i], (i == 0) ? 8'hC : 8'h3, stl_se[i], e_stl[i], $sformatf("stall c%0d", i));

    // Reset during bit 2 of F
    for (int i = 0; i < 3; i++)
      cyc(0, i == 0, 8'hF, 1'b1, e_pre[i], $sformatf("rstw c%0d", i));
    a_if.load_valid = 1'b0; a_if.shift_en = 1'b1;
    #1;
    check("rstw bit2", {27'd0, obs_a}, 32'b01100);
    #2 reset = 1'b1;
    #1;
    check("rstw async", {27'd0, obs_a}, 32'd0);
    @(posedge clock);
    #1;
    check("rstw held", {27'd0, obs_a}, 32'd0);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    // Next word 0110 transmits in full
    for (int i = 0; i < 6; i++)
      cyc(0, i == 0, 8'h6, 1'b1, e_post[i], $sformatf("rstp c%0d", i));

    // WIDTH=8: 0x81 -> 1,0,0,0,0,0,0,1
    for (int i = 0; i < 10; i++)
      cyc(2, i == 0, 8'h81, 1'b1, e_w8[i], $sformatf("w8 c%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
